// File: rtl/nv_ram_fifo_ctrl_80x256.sv
// nv_ram_fifo_ctrl_80x256: valid/ready FIFO controller for an 80x256 two-port
// RAM with registered read (address latch + output register) and 4-entry skid.
// Ports: clk, rstn (sync, active-low); push wr_pvld/wr_prdy/wr_pd;
// pop rd_pvld/rd_prdy/rd_pd; fifo_count; RAM ram_wa/ram_we/ram_di,
// ram_ra/ram_re/ram_ore/ram_dout; pwrbus_ram_pd -> pwrbus_ram_pd_o.
// Option: NV_RAM_FIFO_BYPASS_EN sends pushes into an idle FIFO straight
// to the output buffer (1-cycle latency).
module nv_ram_fifo_ctrl_80x256 (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [255:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [255:0] rd_pd,
  output logic [6:0]   fifo_count,
  output logic [6:0]   ram_wa,
  output logic         ram_we,
  output logic [255:0] ram_di,
  output logic [6:0]   ram_ra,
  output logic         ram_re,
  output logic         ram_ore,
  input  logic [255:0] ram_dout,
  input  logic [31:0]  pwrbus_ram_pd,
  output logic [31:0]  pwrbus_ram_pd_o
);

  localparam int unsigned DEPTH = 80;
  localparam int unsigned WIDTH = 256;
  localparam int unsigned OBUF_DEPTH = 4;
  localparam logic [6:0] LAST = 7'(DEPTH - 1);
  localparam logic [6:0] FULL = 7'(DEPTH);

  logic             rstn_q;
  logic [6:0]       wr_ptr_q, wr_ptr_d;
  logic [6:0]       rd_ptr_q, rd_ptr_d;
  logic [6:0]       ram_count_q, ram_count_d;
  logic [2:0]       credit_q, credit_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [2:0]       obuf_count_q, obuf_count_d;
  logic [WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [WIDTH-1:0] obuf_d [OBUF_DEPTH];

  logic             push, pop, issue, byp, ram_push;
  logic             obuf_wr;
  logic [WIDTH-1:0] obuf_wdata;

  assign pwrbus_ram_pd_o = pwrbus_ram_pd;

  assign wr_prdy  = rstn_q & (ram_count_q < FULL);
  assign push     = wr_pvld & wr_prdy;
  assign rd_pvld  = (obuf_count_q != 3'd0);
  assign rd_pd    = obuf_q[head_q];
  assign pop      = rd_pvld & rd_prdy;

  // Only entries committed at an earlier edge are readable.
  assign issue    = (ram_count_q != 7'd0) & (credit_q != 3'd0);

`ifdef NV_RAM_FIFO_BYPASS_EN
  // Nothing older is anywhere in the pipe, so ordering is kept.
  assign byp = push & (ram_count_q == 7'd0) & ~s1_q & ~s2_q
             & (obuf_count_q < 3'(OBUF_DEPTH));
`else
  assign byp = 1'b0;
`endif

  assign ram_push   = push & ~byp;
  assign ram_we     = ram_push;
  assign ram_wa     = wr_ptr_q;
  assign ram_di     = wr_pd;
  assign ram_re     = issue;
  assign ram_ra     = rd_ptr_q;
  assign ram_ore    = s1_q;

  // s2 and bypass are mutually exclusive (bypass needs s2 low).
  assign obuf_wr    = s2_q | byp;
  assign obuf_wdata = byp ? wr_pd : ram_dout;

  assign fifo_count = ram_count_q
                    + {6'd0, s1_q}
                    + {6'd0, s2_q}
                    + {4'd0, obuf_count_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (ram_push)
      wr_ptr_d = (wr_ptr_q == LAST) ? 7'd0 : wr_ptr_q + 7'd1;

    rd_ptr_d = rd_ptr_q;
    if (issue)
      rd_ptr_d = (rd_ptr_q == LAST) ? 7'd0 : rd_ptr_q + 7'd1;

    ram_count_d = ram_count_q;
    unique case ({ram_push, issue})
      2'b10:   ram_count_d = ram_count_q + 7'd1;
      2'b01:   ram_count_d = ram_count_q - 7'd1;
      default: ram_count_d = ram_count_q;
    endcase

    // A bypassed push takes its output slot just like a read issue.
    credit_d = credit_q;
    unique case ({issue | byp, pop})
      2'b10:   credit_d = credit_q - 3'd1;
      2'b01:   credit_d = credit_q + 3'd1;
      default: credit_d = credit_q;
    endcase

    s1_d = issue;
    s2_d = s1_q;

    obuf_d = obuf_q;
    tail_d = tail_q;
    if (obuf_wr) begin
      obuf_d[tail_q] = obuf_wdata;
      tail_d = tail_q + 2'd1;
    end

    head_d = head_q;
    if (pop)
      head_d = head_q + 2'd1;

    obuf_count_d = obuf_count_q;
    unique case ({obuf_wr, pop})
      2'b10:   obuf_count_d = obuf_count_q + 3'd1;
      2'b01:   obuf_count_d = obuf_count_q - 3'd1;
      default: obuf_count_d = obuf_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstn_q       <= 1'b0;
      wr_ptr_q     <= 7'd0;
      rd_ptr_q     <= 7'd0;
      ram_count_q  <= 7'd0;
      credit_q     <= 3'(OBUF_DEPTH);
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      obuf_count_q <= 3'd0;
    end else begin
      rstn_q       <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      credit_q     <= credit_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      obuf_count_q <= obuf_count_d;
    end
  end

  // Payload storage needs no reset; obuf_count gates its use.
  always_ff @(posedge clk) begin
    obuf_q <= obuf_d;
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x256.sv
// tb_nv_ram_fifo_ctrl_80x256: scoreboard bench with a behavioural RAM model.
// Expected data is queued on accepted push; a monitor pops on each handshake.
module tb_nv_ram_fifo_ctrl_80x256;

  logic         clk = 1'b0;
  logic         rstn;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [255:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [255:0] rd_pd;
  logic [6:0]   fifo_count;
  logic [6:0]   ram_wa;
  logic         ram_we;
  logic [255:0] ram_di;
  logic [6:0]   ram_ra;
  logic         ram_re;
  logic         ram_ore;
  logic [255:0] ram_dout;
  logic [31:0]  pwrbus_ram_pd;
  logic [31:0]  pwrbus_ram_pd_o;

  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_80x256 dut (
    .clk            (clk),
    .rstn           (rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .fifo_count     (fifo_count),
    .ram_wa         (ram_wa),
    .ram_we         (ram_we),
    .ram_di         (ram_di),
    .ram_ra         (ram_ra),
    .ram_re         (ram_re),
    .ram_ore        (ram_ore),
    .ram_dout       (ram_dout),
    .pwrbus_ram_pd  (pwrbus_ram_pd),
    .pwrbus_ram_pd_o(pwrbus_ram_pd_o)
  );

  // Two-port RAM: write port, latched read address, output register.
  logic [255:0] mem [80];
  logic [6:0]   ra_l;
  logic [255:0] dout_r;
  assign ram_dout = dout_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_l <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_l];
  end

  logic [255:0] q [$];
  int checks = 0;
  int errors = 0;
  int acc = 0;
  int pops = 0;
  bit mon_en = 1'b0;
  int we_seen = 0;
  int wa_wrap = 0;
  int ra_wrap = 0;
  int last_wa = -1;
  int last_ra = -1;

  task automatic chk(input bit ok, input string name,
                     input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: model count is pushes minus pops at previous edges.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk(32'(fifo_count) == q.size(), "fifo_count",
          256'(fifo_count), 256'(q.size()));
      if (rd_pvld && rd_prdy) begin
        chk(q.size() != 0, "pop_nonempty", rd_pd, 256'd0);
        if (q.size() != 0) chk(rd_pd == q[0], "pop_data", rd_pd, q[0]);
        if (q.size() != 0) void'(q.pop_front());
        pops++;
      end
      if (ram_we) begin
        we_seen++;
        if (last_wa == 79 && ram_wa == 7'd0) wa_wrap++;
        last_wa = int'(ram_wa);
      end
      if (ram_re) begin
        if (last_ra == 79 && ram_ra == 7'd0) ra_wrap++;
        last_ra = int'(ram_ra);
      end
    end
  end

  task automatic step(input logic v, input logic [255:0] d, input logic r);
    @(negedge clk);
    wr_pvld = v;
    wr_pd   = d;
    rd_prdy = r;
    #2;
    if (wr_pvld && wr_prdy) begin
      q.push_back(wr_pd);
      acc++;
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    chk(q.size() == 0, "drain_timeout", 256'(q.size()), 256'd0);
    step(1'b0, '0, 1'b0);
  endtask

  task automatic fill(input int n, input bit incr);
    int target = acc + n;
    int k = 0;
    int c = 0;
    while (acc < target && c < 400) begin
      step(1'b1, incr ? 256'(k) : rnd256(), 1'b0);
      if (acc > target - n + k) k++;
      c++;
    end
    chk(acc == target, "fill_timeout", 256'(acc), 256'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    @(negedge clk);
    q.delete();
    rstn = 1'b1;
    #1;
    chk(rd_pvld == 1'b0, "rst_rd_pvld", 256'(rd_pvld), 256'd0);
    chk(fifo_count == 7'd0, "rst_count", 256'(fifo_count), 256'd0);
    @(negedge clk);
    #1;
    chk(wr_prdy == 1'b1, "rst_wr_prdy", 256'(wr_prdy), 256'd1);
  endtask

  initial begin
    int lat;
    int p0;
    int target;
    int cyc;
    logic [255:0] a5;
    rstn = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd = '0;
    pwrbus_ram_pd = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    chk(wr_prdy == 1'b0, "reset_wr_prdy", 256'(wr_prdy), 256'd0);
    chk(rd_pvld == 1'b0, "reset_rd_pvld", 256'(rd_pvld), 256'd0);
    chk(fifo_count == 7'd0, "reset_count", 256'(fifo_count), 256'd0);
    chk({ram_we, ram_re, ram_ore} == 3'b000, "reset_ram_en",
        256'({ram_we, ram_re, ram_ore}), 256'd0);
    chk(ram_wa == 7'd0 && ram_ra == 7'd0, "reset_addr",
        256'({ram_wa, ram_ra}), 256'd0);
    chk(pwrbus_ram_pd_o == 32'hDEAD_BEEF, "pwrbus", 256'(pwrbus_ram_pd_o),
        256'(32'hDEAD_BEEF));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk(wr_prdy == 1'b0, "release_wr_prdy", 256'(wr_prdy), 256'd0);
    @(negedge clk);
    #1;
    chk(wr_prdy == 1'b1, "ready_after_release", 256'(wr_prdy), 256'd1);
    mon_en = 1'b1;

    // Single word: count edges after the accept edge until rd_pvld.
    a5 = {32{8'hA5}};
    step(1'b1, a5, 1'b0);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_pvld = 1'b0;
      #1;
      if (rd_pvld) begin
        lat = i;
        break;
      end
    end
`ifdef NV_RAM_FIFO_BYPASS_EN
    chk(lat == 0, "latency", 256'(lat), 256'd0);
    chk(we_seen == 0, "bypass_no_we", 256'(we_seen), 256'd0);
`else
    chk(lat == 3, "latency", 256'(lat), 256'd3);
`endif
    chk(rd_pd == a5, "a5_data", rd_pd, a5);
    drain();

    // Fill to 84 with incrementing words, then 84 back-to-back pops.
    fill(84, 1'b1);
    step(1'b0, '0, 1'b0);
    #1;
    chk(wr_prdy == 1'b0, "full_wr_prdy", 256'(wr_prdy), 256'd0);
    chk(fifo_count == 7'd84, "full_count", 256'(fifo_count), 256'd84);
    step(1'b1, 256'hBAD, 1'b0);
    p0 = pops;
    repeat (84) step(1'b0, '0, 1'b1);
    chk(pops - p0 == 84, "full_drain_pops", 256'(pops - p0), 256'd84);
    step(1'b0, '0, 1'b0);
    #1;
    chk(fifo_count == 7'd0, "empty_count", 256'(fifo_count), 256'd0);

    // Streaming: one pop per cycle once the pipe is primed.
    p0 = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, rnd256(), 1'b1);
      if (i == 9) p0 = pops;
    end
    chk(pops - p0 == 490, "stream_rate", 256'(pops - p0), 256'd490);
    chk(wa_wrap > 0, "wa_wrap", 256'(wa_wrap), 256'd1);
    chk(ra_wrap > 0, "ra_wrap", 256'(ra_wrap), 256'd1);
    drain();

    // Random back-pressure for 10k pushes.
    target = acc + 10000;
    cyc = 0;
    while (acc < target && cyc < 60000) begin
      step(1'($urandom_range(0, 1)), rnd256(),
           1'($urandom_range(0, 99) < 30));
      cyc++;
    end
    chk(acc == target, "random_timeout", 256'(acc), 256'(target));
    drain();

    // Reset with 40 held and two reads in flight.
    fill(42, 1'b0);
    repeat (6) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b1, 256'h1234, 1'b0);
    repeat (3) step(1'b1, rnd256(), 1'b0);
    repeat (8) step(1'b0, '0, 1'b0);
    #1;
    chk(rd_pd == 256'h1234, "post_reset_head", rd_pd, 256'h1234);
    drain();
    repeat (10) step(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_ram_fifo_ctrl_80x256.md
# nv_ram_fifo_ctrl_80x256

Valid/ready FIFO controller that wraps one 80-entry x 256-bit two-port RAM macro, nv_ram_rwsp class, and turns it into an 84-deep in-order FIFO. It sits directly in front of the RAM. It drives the RAM's write port and its registered read port, which has separate address-latch and output-register enables. It captures RAM output into a 4-entry output skid buffer so pop throughput is one entry per cycle.

## Interface
- DEPTH, 80, RAM entries; address width 7.
- WIDTH, 256, payload bits.
- OBUF_DEPTH, 4, output skid entries; equals read latency plus 1.
- clk  input  1  core clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- wr_pvld  input  1  push valid.
- wr_prdy  output  1  push ready.
- wr_pd  input  256  push payload.
- rd_pvld  output  1  pop valid.
- rd_prdy  input  1  pop ready.
- rd_pd  output  256  pop payload, head of the output buffer.
- fifo_count  output  7  entries held: RAM plus in-flight plus output buffer, range 0..84.
- ram_wa  output  7  RAM write address.
- ram_we  output  1  RAM write enable.
- ram_di  output  256  RAM write data, equal to wr_pd.
- ram_ra  output  7  RAM read address.
- ram_re  output  1  RAM read-address latch enable.
- ram_ore  output  1  RAM output-register enable.
- ram_dout  input  256  RAM registered read data.
- pwrbus_ram_pd  input  32  power-down bus from the RAM macro, passed through.
- pwrbus_ram_pd_o  output  32  passed through unchanged to the RAM.

## Operation
- Push is accepted when `wr_pvld & wr_prdy`.
  - `wr_prdy = rstn_q & (ram_count < 80)`.
  - On accept: `ram_we=1`, `ram_wa=wr_ptr`, then wr_ptr advances.
- Pointers wr_ptr and rd_ptr run 0..79 and wrap from 79 to 0. The range is not a power of two, so wrap uses an explicit compare.
- ram_count (0..80):
  - increments on push;
  - decrements on read issue;
  - does neither when both happen in the same cycle.
- Read issue, `ram_re=1` with `ram_ra=rd_ptr`, happens when both hold:
  - ram_count > 0, where the count is registered so only entries committed at an earlier edge are readable;
  - credits > 0.
- On issue, rd_ptr advances.
- Credits:
  - start at 4;
  - decrement on issue;
  - increment on pop;
  - unchanged when issue and pop happen together.
- Read pipeline valid bits:
  - s1 is set by issue; `ram_ore = s1`.
  - s2 = s1 delayed one cycle.
  - s2 means ram_dout holds fresh data, which is written into the output buffer at the next edge.
- ram_ore stays low when s1 is low, so the RAM output register holds.
- Output buffer:
  - 4-entry circular buffer with head/tail/count.
  - `rd_pvld = obuf_count != 0`; `rd_pd = obuf[head]`.
  - Simultaneous write and pop is legal.
  - Overflow is impossible by the credit rule.
- Ordering is strict FIFO.
- Reset (rstn low at an edge, including mid-operation):
  - pointers, ram_count, s1, s2 and obuf_count go to 0; credits go to 4;
  - in-flight reads are discarded;
  - RAM contents are not cleared.

## Timing
- Reset values:
  - wr_prdy=0 while rstn is low; it rises on the first cycle after release.
  - rd_pvld=0, fifo_count=0, ram_we=0, ram_re=0, ram_ore=0.
  - ram_wa and ram_ra are 0. rd_pd is don't-care.
- Push-to-pop latency, empty FIFO without bypass: push accepted at edge E0 gives ram_re during cycle E0..E1, ram_ore during E1..E2, capture at E3, and rd_pvld high after E3. That is 3 cycles.
- Sustained throughput is 1 push and 1 pop per cycle.
- fifo_count is registered and reflects all events of the previous edge.
- When full (fifo_count=84), wr_prdy=0.
- When ram_count hits 80 with free buffer slots, wr_prdy=0 only until the next read issue frees a RAM slot.
- A push while wr_prdy=0 has no effect.
- rd_prdy while rd_pvld=0 has no effect.

## Configuration
- NV_RAM_FIFO_BYPASS_EN
  - Defined:
    - A push that meets all of ram_count==0, s1==0, s2==0 and obuf_count<4 is written straight into the output buffer.
    - ram_we stays 0 and the credit is consumed.
    - rd_pvld is high the cycle after the push, a latency of 1.
    - Ordering is preserved because nothing older is in flight.
  - Undefined: every push goes through the RAM with 3-cycle latency.

## Test plan
- Reset, then push one word 0xA5..A5:
  - with the macro undefined, rd_pvld rises exactly 3 cycles after accept and rd_pd=0xA5..A5;
  - with it defined, rd_pvld rises 1 cycle after accept and ram_we never asserts.
- Push 84 incrementing words 0..83 with rd_prdy=0:
  - wr_prdy falls after the 84th accept and fifo_count=84;
  - then pop all with rd_prdy=1: 84 consecutive pops come out in order 0..83 and fifo_count returns to 0.
- Streaming with wr_pvld=1 and rd_prdy=1 for 500 cycles:
  - after the initial latency, one pop per cycle;
  - ram_wa/ram_ra wrap 79 to 0 with no data corruption.
- Random back-pressure, with rd_prdy asserted 30% of the time and random wr_pvld, for 10k transactions:
  - scoreboard matches in order;
  - output buffer never exceeds 4;
  - ram_count never exceeds 80.
- Assert rstn=0 for one cycle with 40 entries held and 2 reads in flight:
  - next cycle rd_pvld=0, fifo_count=0 and wr_prdy=1;
  - a following push of 0x1234 is the first word popped.
